// File: rtl/spybuffer_read_arbiter.sv
// Round-robin read arbiter that drains several first-word-fall-through FIFOs
// into a single registered valid/ready output stream, one burst per grant.
//
// Ports
//   rclk, rrst         clock and synchronous active-high reset
//   ch_enable          per-channel arbitration enable mask
//   fifo_rempty        per-channel FIFO empty flag
//   fifo_ralmostempty  per-channel flag, high when at most one word remains
//   fifo_rdata         FWFT read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rinc          one-hot-or-zero read strobe (combinational)
//   m_data/m_chan      registered output word and its source channel
//   m_last             final word of a burst
//   m_valid/m_ready    output handshake
module spybuffer_read_arbiter #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                         rclk,
   input  logic                         rrst,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic [NUM_CH-1:0]            fifo_rempty,
   input  logic [NUM_CH-1:0]            fifo_ralmostempty,
   input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rdata,
   output logic [NUM_CH-1:0]            fifo_rinc,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic [$clog2(NUM_CH)-1:0]    m_chan,
   output logic                         m_last,
   output logic                         m_valid,
   input  logic                         m_ready
);

   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]       grant_q, grant_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [CH_W-1:0]       m_chan_q, m_chan_d;
   logic                  m_last_q, m_last_d;
   logic                  m_valid_q, m_valid_d;

   logic [NUM_CH-1:0]     eligible;
   logic [CH_W-1:0]       pick;
   logic                  pick_vld;
   int unsigned           idx;
   logic [DATA_WIDTH-1:0] words [NUM_CH];
   logic [DATA_WIDTH-1:0] gnt_word;
   logic [CH_W-1:0]       gnt_wrap;
   logic [CNT_W-1:0]      count_inc;
   logic                  out_free;
   logic                  last_word;
   logic [NUM_CH-1:0]     rinc;

   assign eligible  = ch_enable & ~fifo_rempty;
   assign out_free  = !m_valid_q || m_ready;
   assign count_inc = count_q + CNT_W'(1);
   assign gnt_wrap  = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);

   // Split the flat read-data bus into per-channel words
   for (genvar g = 0; g < NUM_CH; g++) begin : g_words
      assign words[g] = fifo_rdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign gnt_word = words[grant_q];

   // First eligible channel searching upward from rr_ptr, wrapping at NUM_CH
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!pick_vld && eligible[CH_W'(idx)]) begin
            pick     = CH_W'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   // Next-state and output-register load
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      count_d   = count_q;
      m_data_d  = m_data_q;
      m_chan_d  = m_chan_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;
      rinc      = '0;
      last_word = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (out_free) m_valid_d = 1'b0;
            if (pick_vld) begin
               grant_d = pick;
               count_d = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (out_free) begin
               if (!fifo_rempty[grant_q]) begin
                  last_word = (count_inc == CNT_W'(MAX_BURST)) ||
                              fifo_ralmostempty[grant_q] || !ch_enable[grant_q];
                  rinc      = NUM_CH'(1) << grant_q;
                  m_data_d  = gnt_word;
                  m_chan_d  = grant_q;
                  m_last_d  = last_word;
                  m_valid_d = 1'b1;
                  count_d   = count_inc;
                  if (last_word) begin
                     state_d  = IDLE;
                     rr_ptr_d = gnt_wrap;
                  end
               end else begin
                  // Grant ran dry before a last word could be flagged
                  m_valid_d = 1'b0;
                  state_d   = IDLE;
                  rr_ptr_d  = gnt_wrap;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Never pop a FIFO while reset is discarding the output register
   assign fifo_rinc = rrst ? '0 : rinc;

   // State and output registers
   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         count_q   <= '0;
         m_data_q  <= '0;
         m_chan_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         count_q   <= count_d;
         m_data_q  <= m_data_d;
         m_chan_q  <= m_chan_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign m_data  = m_data_q;
   assign m_chan  = m_chan_q;
   assign m_last  = m_last_q;
   assign m_valid = m_valid_q;

endmodule

// File: doc/spybuffer_read_arbiter.md
SPYBUFFER_READ_ARBITER -- requirements
Module: spybuffer_read_arbiter

Interface
REQ-001 The block SHALL provide parameter NUM_CH, default 4, number of FIFO read ports arbitrated (2..16).
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 32, FIFO word width.
REQ-003 The block SHALL provide parameter MAX_BURST, default 8, maximum words per grant (1..255).
REQ-004 The block SHALL have port rclk  input  1  single clock; all logic rising-edge.
REQ-005 The block SHALL have port rrst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port ch_enable  input  NUM_CH  per-channel arbitration enable mask.
REQ-007 The block SHALL have port fifo_rempty  input  NUM_CH  per-channel FIFO empty flag, read domain.
REQ-008 The block SHALL have port fifo_ralmostempty  input  NUM_CH  per-channel flag, high when at most one word remains.
REQ-009 The block SHALL have port fifo_rdata  input  NUM_CH*DATA_WIDTH  first-word-fall-through read data; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port fifo_rinc  output  NUM_CH  one-hot-or-zero read-increment strobe per channel.
REQ-011 The block SHALL have port m_data  output  DATA_WIDTH  registered output word.
REQ-012 The block SHALL have port m_chan  output  clog2(NUM_CH)  source channel of m_data.
REQ-013 The block SHALL have port m_last  output  1  marks final word of a burst.
REQ-014 The block SHALL have port m_valid  output  1  output word valid.
REQ-015 The block SHALL have port m_ready  input  1  downstream accept; transfer when m_valid & m_ready.

Function
REQ-016 The block SHALL implement states IDLE, BURST.
REQ-017 A channel SHALL be eligible when ch_enable[i]=1 and fifo_rempty[i]=0.
REQ-018 In IDLE, when any channel is eligible, the block SHALL register grant = first eligible channel searching upward (modulo NUM_CH) from rr_ptr, clear burst count, and enter BURST next cycle; no fifo_rinc in IDLE.
REQ-019 rr_ptr SHALL reset to 0 and, on leaving BURST, load (grant+1) mod NUM_CH.
REQ-020 The output register SHALL be free when m_valid=0 or m_ready=1.
REQ-021 In BURST, when the output register is free and fifo_rempty[grant]=0, the block SHALL in the same cycle assert fifo_rinc[grant] and load m_data=word[grant], m_chan=grant, m_valid=1, and increment the burst count.
REQ-022 The loaded word SHALL carry m_last=1 when burst count reaches MAX_BURST, or fifo_ralmostempty[grant]=1, or ch_enable[grant]=0; the block SHALL then return to IDLE next cycle.
REQ-023 In BURST, if fifo_rempty[grant]=1 with the output register free, the block SHALL go to IDLE without loading, and SHALL assert m_last=1 on no word retroactively.
REQ-024 When the output register is free and no word is loaded, m_valid SHALL drop to 0 next cycle.
REQ-025 m_data, m_chan, m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 fifo_rinc SHALL never assert for a channel whose fifo_rempty is 1 or which is not granted; at most one bit high per cycle.
REQ-027 Throughput SHALL be one word per cycle within a burst with m_ready held high; one idle arbitration cycle between bursts.
REQ-028 Burst count SHALL be clog2(MAX_BURST+1) bits and SHALL not wrap.

Reset
REQ-029 While rrst=1 the block SHALL force state IDLE, rr_ptr=0, grant=0, count=0, fifo_rinc=0, m_valid=0, m_last=0, m_chan=0, m_data=0, taking effect at the next rclk edge.
REQ-030 Reset asserted mid-burst SHALL discard the pending output word and issue no further fifo_rinc; no word is re-read.

Verification
REQ-031 Ch1 holds 3 words, others empty, m_ready=1 -> IDLE 1 cycle, then rinc[1] 3 consecutive cycles, m_chan=1, m_last on word 3, rr_ptr=2.
REQ-032 All 4 channels hold 20 words, MAX_BURST=8 -> grant order 0,1,2,3,0; each burst exactly 8 words, m_last on 8th.
REQ-033 m_ready low 5 cycles mid-burst -> m_data/m_chan stable, no fifo_rinc during stall, no word lost or duplicated.
REQ-034 ch_enable[2]=0 with ch2 non-empty -> ch2 never granted; deasserting ch_enable[grant] mid-burst ends burst with m_last on next loaded word.
REQ-035 rrst pulsed during ch0 burst word 4 -> m_valid=0 next cycle, fifo_rinc=0, after release grant restarts at ch0.
REQ-036 Scoreboard: concatenated per-channel output words equal per-channel FIFO write order under random m_ready and random fill.
